// File: rtl/banked_sram_pkg.sv
// rtl/banked_sram_pkg.sv - shared types and default parameters for banked_sram_ctrl
package banked_sram_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_BANK_DEPTH = 1024;
    localparam int DEF_NUM_BANKS  = 16;

    // INIT clears every bank; IDLE serves requests until the next reset.
    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - one single-port SRAM bank with per-lane write enables and registered read
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (read register only)
//   en_i, we_i  - access enable, 1 = write / 0 = read
//   addr_i      - word address
//   be_i        - per-lane write enables
//   wdata_i     - write word (LANES lanes of LANE_W bits)
//   rdata_o     - registered read word, updated only by a read access
module sram_bank #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH),
    localparam int WORD_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [LANES-1:0]  be_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_i[l]) begin
                    mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // The read register only moves on a read, so a stalled response stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_sram_ctrl.sv
// rtl/banked_sram_ctrl.sv - multi-bank SRAM controller with zero-clear init sweep and optional byte parity
//
// Optional feature macro: BANKED_SRAM_PARITY_EN (even parity per byte, adds input inj_par_err).
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   inj_par_err                   - (parity build only) invert stored parity of written bytes
//   req_valid/req_ready           - request handshake
//   req_we, req_addr, req_be,
//   req_wdata                     - request: direction, {bank, word} address, byte enables, data
//   rsp_valid/rsp_ready           - read response handshake
//   rsp_rdata, rsp_err            - read data and parity error flag
//   init_done                     - zero-clear sweep finished
module banked_sram_ctrl
    import banked_sram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    localparam int BANK_AW   = $clog2(BANK_DEPTH),
    localparam int SEL_W     = $clog2(NUM_BANKS),
    localparam int ADDR_W    = SEL_W + BANK_AW,
    localparam int BYTES     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef BANKED_SRAM_PARITY_EN
    input  logic              inj_par_err,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BYTES-1:0]  req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

`ifdef BANKED_SRAM_PARITY_EN
    localparam int LANE_W = 9;   // {parity, byte}
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = BYTES * LANE_W;
    localparam logic [BANK_AW-1:0] LAST_WORD = BANK_AW'(BANK_DEPTH - 1);

    state_e             state_q, state_d;
    logic [BANK_AW-1:0] init_cnt_q, init_cnt_d;
    logic               init_done_q, init_done_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic               accept;
    logic [SEL_W-1:0]   req_sel;
    logic [NUM_BANKS-1:0] bank_en;
    logic               bank_we;
    logic [BANK_AW-1:0] bank_addr;
    logic [BYTES-1:0]   bank_be;
    logic [WORD_W-1:0]  bank_wdata;
    logic [WORD_W-1:0]  wr_word;
    logic [WORD_W-1:0]  rd_word;
    logic [WORD_W-1:0]  bank_rdata [NUM_BANKS];

    assign req_ready = init_done_q && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign req_sel   = req_addr[ADDR_W-1 -: SEL_W];

    // Build the stored lanes of a write word; parity makes each lane XOR to 0.
    always_comb begin
        wr_word = '0;
        for (int b = 0; b < BYTES; b++) begin
`ifdef BANKED_SRAM_PARITY_EN
            wr_word[b*LANE_W +: LANE_W] = {(^req_wdata[b*8 +: 8]) ^ inj_par_err, req_wdata[b*8 +: 8]};
`else
            wr_word[b*LANE_W +: LANE_W] = req_wdata[b*8 +: 8];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            sel_q       <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        sel_d       = sel_q;
        bank_en     = '0;
        bank_we     = 1'b1;
        bank_addr   = init_cnt_q;
        bank_be     = '1;
        bank_wdata  = '0;   // all-zero lanes also carry correct even parity
        case (state_q)
            INIT: begin
                bank_en = '1;
                if (init_cnt_q == LAST_WORD) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                bank_we    = req_we;
                bank_addr  = req_addr[BANK_AW-1:0];
                bank_be    = req_be;
                bank_wdata = wr_word;
                if (accept) begin
                    bank_en[req_sel] = 1'b1;
                end
                if (accept && !req_we) begin
                    rsp_valid_d = 1'b1;
                    sel_d       = req_sel;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sram_bank #(
            .LANES  (BYTES),
            .LANE_W (LANE_W),
            .DEPTH  (BANK_DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (bank_en[g]),
            .we_i    (bank_we),
            .addr_i  (bank_addr),
            .be_i    (bank_be),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[g])
        );
    end

    // Output mux follows the registered select, not the live request address.
    assign rd_word = bank_rdata[sel_q];

    always_comb begin
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            rsp_rdata[b*8 +: 8] = rd_word[b*LANE_W +: 8];
`ifdef BANKED_SRAM_PARITY_EN
            rsp_err = rsp_err | (^rd_word[b*LANE_W +: LANE_W]);
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// tb/tb_banked_sram_ctrl.sv - scoreboard testbench for banked_sram_ctrl
module tb_banked_sram_ctrl;

    localparam int DATA_W     = 32;
    localparam int BANK_DEPTH = 1024;
    localparam int NUM_BANKS  = 16;
    localparam int ADDR_W     = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              inj;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [3:0]  model_bad [int];

    always #5 clk = ~clk;

    banked_sram_ctrl #(
        .DATA_W     (DATA_W),
        .BANK_DEPTH (BANK_DEPTH),
        .NUM_BANKS  (NUM_BANKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BANKED_SRAM_PARITY_EN
        .inj_par_err (inj),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        inj       = 1'b0;
    endtask

    // Entered and left at posedge+1; the model is updated at the accepting edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                         input logic [31:0] data, input logic inj_v);
        bit          got = 0;
        logic [31:0] cur;
        logic [3:0]  bad;
        exp_t        e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = data;
        inj       = inj_v;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                got = 1;
                cur = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 32'h0;
                bad = model_bad.exists(int'(addr)) ? model_bad[int'(addr)] : 4'h0;
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            cur[b*8 +: 8] = data[b*8 +: 8];
                            bad[b]        = inj_v;
                        end
                    end
                    model_mem[int'(addr)] = cur;
                    model_bad[int'(addr)] = bad;
                end else begin
                    e.data = cur;
`ifdef BANKED_SRAM_PARITY_EN
                    e.err = |bad;
`else
                    e.err = 1'b0;
`endif
                    exp_q.push_back(e);
                end
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout addr=%h: request not accepted within 50 cycles", addr);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got data=%h err=%b, required no response", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_rdata !== e.data || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp_data: got data=%h err=%b, required data=%h err=%b",
                                 rsp_rdata, rsp_err, e.data, e.err);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
        end
    endtask

    // Called at posedge+1 of cycle 1 (the first cycle with rst_n high, init_cnt=0).
    task automatic test_init_sweep(input bit hold_req);
        bit ready_seen = 0;
        if (hold_req) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 14'h0005;
            req_be    = 4'hF;
            req_wdata = 32'hFFFF_FFFF;
        end
        for (int k = 1; k <= BANK_DEPTH + 1; k++) begin
            if (k == BANK_DEPTH + 1) idle();
            @(negedge clk);
            if (k <= BANK_DEPTH && req_ready) ready_seen = 1;
            if (k == 1) begin
                checks++;
                if (init_done !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL init_start: got init_done=%b req_ready=%b, required 0 0", init_done, req_ready);
                end
            end
            if (k == BANK_DEPTH) begin
                checks++;
                if (init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL init_early: got init_done=%b at cycle %0d, required 0", init_done, k);
                end
            end
            if (k == BANK_DEPTH + 1) begin
                checks++;
                if (init_done !== 1'b1 || req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL init_done: got init_done=%b req_ready=%b at cycle %0d, required 1 1",
                             init_done, req_ready, k);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL init_ready: got req_ready=1 during INIT, required 0");
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got done=%b valid=%b rdata=%h err=%b ready=%b, required 0 0 0 0 0",
                     init_done, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        rst_n = 1'b1;
        test_init_sweep(0);
        issue(0, 14'h3FFF, 4'h0, 32'h0, 0);
        idle();
        wait_drain();
    endtask

    task automatic test_write_merge();
        issue(1, 14'h0400, 4'hF, 32'hDEAD_BEEF, 0);
        issue(1, 14'h0400, 4'h1, 32'h0000_00AA, 0);
        issue(0, 14'h0400, 4'h0, 32'h0, 0);
        issue(0, 14'h0000, 4'h0, 32'h0, 0);
        idle();
        wait_drain();
        checks++;
        if (model_mem[int'(14'h0400)] !== 32'hDEAD_BEAA) begin
            errors++;
            $display("FAIL merge_model: got %h, required DEADBEAA", model_mem[int'(14'h0400)]);
        end
    endtask

    task automatic test_stall();
        issue(1, 14'h0001, 4'hF, 32'h1111_1111, 0);
        issue(1, 14'h0401, 4'hF, 32'h2222_2222, 0);
        issue(1, 14'h3C01, 4'hF, 32'h3333_3333, 0);
        idle();
        rsp_ready = 1'b0;
        issue(0, 14'h0001, 4'h0, 32'h0, 0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 14'h0401;
        for (int k = 0; k < 3; k++) begin
            req_addr = (k == 1) ? 14'h3C01 : 14'h0401;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_1111 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got ready=%b valid=%b rdata=%h err=%b, required 0 1 11111111 0",
                         req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        issue(0, 14'h0401, 4'h0, 32'h0, 0);
        issue(0, 14'h3C01, 4'h0, 32'h0, 0);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        time t0;
        int  n = 24;
        issue(1, 14'h2345, 4'hF, 32'hABCD_1234, 0);
        issue(0, 14'h2345, 4'h0, 32'h0, 0);
        t0 = $time;
        for (int i = 0; i < n; i++) begin
            issue(1'($urandom_range(0, 1)), {4'($urandom_range(0, NUM_BANKS - 1)), 10'($urandom_range(0, 3))},
                  4'($urandom_range(0, 15)), $urandom, 0);
        end
        checks++;
        if ($time - t0 != time'(n * 10)) begin
            errors++;
            $display("FAIL b2b_rate: got %0t for %0d requests, required %0d", $time - t0, n, n * 10);
        end
        idle();
        wait_drain();
    endtask

    task automatic test_reset_mid_rsp();
        rsp_ready = 1'b0;
        issue(0, 14'h0400, 4'h0, 32'h0, 0);
        idle();
        #2;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_rsp_pre: got rsp_valid=%b, required 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rsp_reset: got valid=%b rdata=%h done=%b ready=%b, required 0 0 0 0",
                     rsp_valid, rsp_rdata, init_done, req_ready);
        end
        exp_q.delete();
        model_mem.delete();
        model_bad.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_init_sweep(1);
        issue(0, 14'h0005, 4'h0, 32'h0, 0);
        issue(0, 14'h0400, 4'h0, 32'h0, 0);
        issue(0, 14'h0001, 4'h0, 32'h0, 0);
        idle();
        wait_drain();
    endtask

`ifdef BANKED_SRAM_PARITY_EN
    task automatic test_parity();
        issue(1, 14'h0010, 4'hF, 32'h1234_5678, 1);
        issue(0, 14'h0010, 4'h0, 32'h0, 0);
        issue(1, 14'h0010, 4'hF, 32'h1234_5678, 0);
        issue(0, 14'h0010, 4'h0, 32'h0, 0);
        issue(1, 14'h0811, 4'h4, 32'h00FF_0000, 1);
        issue(0, 14'h0811, 4'h0, 32'h0, 0);
        idle();
        wait_drain();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        inj = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_write_merge();
        test_stall();
        test_back_to_back();
`ifdef BANKED_SRAM_PARITY_EN
        test_parity();
`endif
        test_reset_mid_rsp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_sram_ctrl.md
BANKED_SRAM_CTRL -- requirements
Module: banked_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter BANK_DEPTH, default 1024: words per bank; power of two.
REQ-003 SHALL have parameter NUM_BANKS, default 16: bank count; power of two, at least 2.
REQ-004 SHALL derive BANK_AW = clog2(BANK_DEPTH), SEL_W = clog2(NUM_BANKS) and ADDR_W = SEL_W + BANK_AW.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-009 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W bits: upper SEL_W bits select the bank, lower BANK_AW bits select the word.
REQ-012 SHALL have port req_be, input, DATA_W/8 bits: write byte enables.
REQ-013 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-014 SHALL have port rsp_valid, output, 1 bit: read data is valid.
REQ-015 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the read data.
REQ-016 SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-017 SHALL have port rsp_err, output, 1 bit: parity error on the returned word.
REQ-018 SHALL have port init_done, output, 1 bit: the zero-clear sweep is complete.

Function
REQ-019 SHALL accept a request only in a cycle where req_valid and req_ready are both 1.
REQ-020 SHALL drive req_ready = init_done AND (NOT rsp_valid OR rsp_ready).
REQ-021 SHALL, for an accepted write, update only the bytes of the addressed bank word whose req_be bit is 1; all other banks and bytes are untouched.
REQ-022 SHALL, for an accepted write, produce no response.
REQ-023 SHALL, for a read accepted in cycle N, assert rsp_valid in cycle N+1 with that word's data.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL support back-to-back reads at one per cycle when rsp_ready=1.
REQ-026 SHALL register the bank select for output muxing, so the response comes from the bank that was read even if req_addr changes.
REQ-027 SHALL have an FSM with states INIT and IDLE.
REQ-028 SHALL, in INIT, write zero to word init_cnt of every bank in parallel, with init_cnt incrementing from 0 to BANK_DEPTH-1.
REQ-029 SHALL move from INIT to IDLE on the cycle after init_cnt reaches BANK_DEPTH-1, with init_done=1 from that cycle.
REQ-030 SHALL hold req_ready=0 throughout INIT and accept no request in INIT.
REQ-031 SHALL treat IDLE as terminal; only reset leaves IDLE.
REQ-032 SHALL return written data on a read to the same address in the cycle after the write is accepted; no hazard stall is needed.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=INIT, init_cnt=0, init_done=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-034 SHALL, on reset asserted mid-response, drop the pending response without delivering it.
REQ-035 SHALL, after reset is released, always re-run the full INIT sweep.

Configuration
REQ-036 SHALL use macro BANKED_SRAM_PARITY_EN to compile parity in or out.
REQ-037 SHALL, when BANKED_SRAM_PARITY_EN is defined, store one even-parity bit per byte and write the parity bits of enabled bytes together with the data.
REQ-038 SHALL, when BANKED_SRAM_PARITY_EN is defined, recompute parity on read and set rsp_err=1 if any byte mismatches.
REQ-039 SHALL, when BANKED_SRAM_PARITY_EN is defined, add input port inj_par_err (1 bit), which inverts the stored parity of every enabled byte of an accepted write.
REQ-040 SHALL, when BANKED_SRAM_PARITY_EN is defined, have INIT write parity bits consistent with zero data.
REQ-041 SHALL, when BANKED_SRAM_PARITY_EN is undefined, store no parity, tie rsp_err to 0 and omit port inj_par_err.

Structure
REQ-042 SHALL define in package banked_sram_pkg: the FSM state enum (INIT, IDLE) and the default values of DATA_W, BANK_DEPTH and NUM_BANKS.
REQ-043 SHALL use one sub-module, sram_bank: a single parameterised bank with byte-enable write and registered read, instantiated NUM_BANKS times with a generate loop.

Verification
REQ-044 SHALL check: reset, then run BANK_DEPTH+1 cycles -> init_done=1 exactly at cycle BANK_DEPTH+1; a read of 0x3FFF returns 0x00000000.
REQ-045 SHALL check: write 0xDEADBEEF to 0x0400 with be=0xF, then write 0x000000AA to 0x0400 with be=0x1 -> read of 0x0400 returns 0xDEADBEAA; read of 0x0000 returns 0.
REQ-046 SHALL check: reads of 0x0001, 0x0401 and 0x3C01 issued with rsp_ready=0 for 3 cycles -> req_ready=0 during the stall, first response held stable, all three data words delivered in order.
REQ-047 SHALL check: req_valid=1 during INIT -> no accept, and memory is unchanged after init_done.
REQ-048 SHALL check: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately and INIT restarts at init_cnt=0.
REQ-049 SHALL check, with BANKED_SRAM_PARITY_EN defined: write 0x12345678 with inj_par_err=1 -> read returns 0x12345678 with rsp_err=1; a clean rewrite then reads with rsp_err=0.
